// File: rtl/mem_access_arbiter_pkg.sv
// Shared definitions for the memory access arbiter: default widths and the
// one-hot arbiter state encoding.
package mem_access_arbiter_pkg;

    localparam int DEF_XLEN          = 32;
    localparam int DEF_PC_BITWIDTH   = 32;
    localparam int DEF_MEM_ADDR_BITS = 16;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_FETCH = 4'b0010,
        S_DATA  = 4'b0100,
        S_DRAIN = 4'b1000
    } arb_state_e;

endpackage

// File: rtl/mem_req_slot.sv
// One-deep pending request slot. A load overrides a clear in the same cycle,
// so a request arriving as the old one retires is never lost.
module mem_req_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    output logic         pending_o,
    output logic [W-1:0] data_o
);

    logic         pending_q, pending_d;
    logic [W-1:0] data_q, data_d;

    always_comb begin
        pending_d = pending_q;
        data_d    = data_q;
        if (load_i) begin
            pending_d = 1'b1;
            data_d    = data_i;
        end else if (clear_i) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    assign pending_o = pending_q;
    assign data_o    = data_q;

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one memory controller between an instruction fetch port and a
// load/store port; data has fixed priority, one transaction outstanding.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int XLEN          = DEF_XLEN,
    parameter int PC_BITWIDTH   = DEF_PC_BITWIDTH,
    parameter int MEM_ADDR_BITS = DEF_MEM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sync_reset,
    input  logic                     fetch_re,
    input  logic [PC_BITWIDTH-1:0]   fetch_addr,
    output logic                     fetch_done,
    output logic [XLEN-1:0]          fetch_rdata,
    output logic [MEM_ADDR_BITS-1:0] fetch_addr_ack,
    output logic                     dram_rw_pending,
    input  logic                     data_re,
    input  logic                     data_we,
    input  logic [PC_BITWIDTH-1:0]   data_addr,
    input  logic [XLEN-1:0]          data_wdata,
    input  logic [XLEN/8-1:0]        data_be,
    output logic                     data_done,
    output logic [XLEN-1:0]          data_rdata,
    output logic                     data_overrun,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [XLEN-1:0]          mem_wdata,
    output logic [XLEN/8-1:0]        mem_be,
    input  logic                     mem_done,
    input  logic [XLEN-1:0]          mem_rdata
);

    localparam int BEW = XLEN / 8;
    localparam int DW  = 1 + MEM_ADDR_BITS + XLEN + BEW;  // {we, word addr, wdata, be}

    arb_state_e state_q, state_d;

    logic                     f_pend, d_pend, d_pend_next;
    logic [MEM_ADDR_BITS-1:0] f_slot, f_eff;
    logic [DW-1:0]            d_slot, d_new, d_eff;
    logic                     data_req, busy, can_issue;
    logic                     d_accept, d_waiting, d_wants;
    logic                     issue_data, issue_fetch;
    logic                     f_load, f_clear, d_clear;
    logic                     addr_unused;

    logic                     mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic [MEM_ADDR_BITS-1:0] mem_addr_q, mem_addr_d, ack_q, ack_d;
    logic [XLEN-1:0]          mem_wdata_q, mem_wdata_d;
    logic [BEW-1:0]           mem_be_q, mem_be_d;
    logic                     fetch_done_q, fetch_done_d, data_done_q, data_done_d;
    logic [XLEN-1:0]          fetch_rdata_q, fetch_rdata_d, data_rdata_q, data_rdata_d;
    logic                     overrun_q, overrun_d, dram_q, dram_d;

    assign addr_unused = ^{fetch_addr[PC_BITWIDTH-1:MEM_ADDR_BITS+2], fetch_addr[1:0],
                           data_addr[PC_BITWIDTH-1:MEM_ADDR_BITS+2], data_addr[1:0]};

    assign data_req  = data_re | data_we;
    assign busy      = (state_q == S_FETCH) || (state_q == S_DATA) || (state_q == S_DRAIN);
    assign can_issue = !sync_reset && ((state_q == S_IDLE) || (busy && mem_done));

    // The data slot stays occupied until its transaction completes, so any
    // data request arriving while it is queued or in flight is an overrun.
    assign d_new     = {data_we, data_addr[MEM_ADDR_BITS+1:2], data_wdata, data_be};
    assign d_accept  = data_req && !d_pend && !sync_reset;
    assign d_waiting = d_pend && (state_q != S_DATA);
    assign d_wants   = d_waiting || d_accept;
    assign d_eff     = d_pend ? d_slot : d_new;
    assign d_clear   = sync_reset || ((state_q == S_DATA) && mem_done);
    assign d_pend_next = d_accept ? 1'b1 : (d_clear ? 1'b0 : d_pend);

    // A fetch request bypasses its own slot when it can go straight out.
    assign f_eff       = fetch_re ? fetch_addr[MEM_ADDR_BITS+1:2] : f_slot;
    assign issue_data  = can_issue && d_wants;
    assign issue_fetch = can_issue && !d_wants && (fetch_re || f_pend);
    assign f_load      = fetch_re && !issue_fetch && !sync_reset;
    assign f_clear     = issue_fetch || sync_reset;

    mem_req_slot #(.W(MEM_ADDR_BITS)) u_fetch_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (f_load),
        .clear_i   (f_clear),
        .data_i    (fetch_addr[MEM_ADDR_BITS+1:2]),
        .pending_o (f_pend),
        .data_o    (f_slot)
    );

    mem_req_slot #(.W(DW)) u_data_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (d_accept),
        .clear_i   (d_clear),
        .data_i    (d_new),
        .pending_o (d_pend),
        .data_o    (d_slot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mem_re_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            fetch_done_q  <= 1'b0;
            data_done_q   <= 1'b0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            ack_q         <= '0;
            overrun_q     <= 1'b0;
            dram_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_re_q      <= mem_re_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_be_q      <= mem_be_d;
            fetch_done_q  <= fetch_done_d;
            data_done_q   <= data_done_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
            ack_q         <= ack_d;
            overrun_q     <= overrun_d;
            dram_q        <= dram_d;
        end
    end

    // A sync_reset with a transaction still open parks in S_DRAIN to swallow its mem_done.
    always_comb begin
        state_d = state_q;
        if (sync_reset)
            state_d = (busy && !mem_done) ? S_DRAIN : S_IDLE;
        else if (issue_data)
            state_d = S_DATA;
        else if (issue_fetch)
            state_d = S_FETCH;
        else if (busy && mem_done)
            state_d = S_IDLE;
    end

    always_comb begin
        mem_re_d      = issue_fetch || (issue_data && !d_eff[DW-1]);
        mem_we_d      = issue_data && d_eff[DW-1];
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        mem_be_d      = mem_be_q;
        if (issue_data) begin
            mem_addr_d  = d_eff[DW-2 -: MEM_ADDR_BITS];
            mem_wdata_d = d_eff[BEW +: XLEN];
            mem_be_d    = d_eff[BEW-1:0];
        end else if (issue_fetch) begin
            mem_addr_d  = f_eff;
        end
        fetch_done_d  = (state_q == S_FETCH) && mem_done && !sync_reset;
        data_done_d   = (state_q == S_DATA) && mem_done && !sync_reset;
        fetch_rdata_d = fetch_done_d ? mem_rdata : fetch_rdata_q;
        data_rdata_d  = data_done_d ? mem_rdata : data_rdata_q;
        ack_d         = fetch_done_d ? mem_addr_q : ack_q;
        overrun_d     = overrun_q || (data_req && d_pend && !sync_reset);
        dram_d        = d_pend_next || (state_d == S_DATA);
    end

    assign mem_re          = mem_re_q;
    assign mem_we          = mem_we_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;
    assign mem_be          = mem_be_q;
    assign fetch_done      = fetch_done_q;
    assign data_done       = data_done_q;
    assign fetch_rdata     = fetch_rdata_q;
    assign data_rdata      = data_rdata_q;
    assign fetch_addr_ack  = ack_q;
    assign data_overrun    = overrun_q;
    assign dram_rw_pending = dram_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Bench for mem_access_arbiter: a transaction-level port/memory model predicts
// strobes, done pulses and status one cycle ahead of every sample.
module tb_mem_access_arbiter;

  localparam int MAW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sync_reset = 1'b0;
  logic fetch_re = 1'b0, data_re = 1'b0, data_we = 1'b0, mem_done = 1'b0;
  logic [31:0] fetch_addr = '0, data_addr = '0, data_wdata = '0, mem_rdata = '0;
  logic [3:0] data_be = '0;
  logic fetch_done, data_done, dram_rw_pending, data_overrun, mem_re, mem_we;
  logic [31:0] fetch_rdata, data_rdata, mem_wdata;
  logic [MAW-1:0] fetch_addr_ack, mem_addr;
  logic [3:0] mem_be;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset),
    .fetch_re(fetch_re), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .fetch_rdata(fetch_rdata), .fetch_addr_ack(fetch_addr_ack),
    .dram_rw_pending(dram_rw_pending),
    .data_re(data_re), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_be(data_be), .data_done(data_done),
    .data_rdata(data_rdata), .data_overrun(data_overrun),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_done(mem_done), .mem_rdata(mem_rdata)
  );

  int n_total = 0;
  int n_bad = 0;
  int n_fd = 0;
  int n_dd = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Port/memory model state. in_kind: 0 fetch, 1 data, 2 abandoned by sync_reset.
  bit data_busy, data_unissued, fetch_unissued, inflight, in_we;
  bit stray_done, fix_rd_en;
  int in_kind, cnt, mem_lat;
  logic [MAW-1:0] fetch_w;
  logic dq_we;
  logic [MAW-1:0] dq_w;
  logic [31:0] dq_wd, fix_rd;
  logic [3:0] dq_be;
  logic [MAW-1:0] exp_q[$];

  // Expectations for the next sample point.
  bit e_re, e_we, e_fd, e_dd, e_dd_load, e_dram, e_ovr;
  logic [MAW-1:0] e_addr, e_ack;
  logic [31:0] e_wd, e_rd;
  logic [3:0] e_be;

  task automatic model_clear();
    data_busy = 0; data_unissued = 0; fetch_unissued = 0; inflight = 0; in_we = 0;
    in_kind = 0; cnt = 0; exp_q.delete();
    e_re = 0; e_we = 0; e_fd = 0; e_dd = 0; e_dd_load = 0; e_dram = 0; e_ovr = 0;
    e_addr = '0; e_ack = '0; e_wd = '0; e_rd = '0; e_be = '0;
  endtask

  task automatic check_outputs();
    check("mem_re", mem_re, e_re);
    check("mem_we", mem_we, e_we);
    if (e_re || e_we) check("mem_addr", mem_addr, e_addr);
    if (e_we) begin
      check("mem_wdata", mem_wdata, e_wd);
      check("mem_be", mem_be, e_be);
    end
    check("fetch_done", fetch_done, e_fd);
    if (e_fd) begin
      check("fetch_rdata", fetch_rdata, e_rd);
      check("fetch_addr_ack", fetch_addr_ack, e_ack);
    end
    check("data_done", data_done, e_dd);
    if (e_dd && e_dd_load) check("data_rdata", data_rdata, e_rd);
    check("dram_rw_pending", dram_rw_pending, e_dram);
    check("data_overrun", data_overrun, e_ovr);
    if (fetch_done) n_fd++;
    if (data_done) n_dd++;
  endtask

  // One clock: check last prediction, drive new inputs, predict next sample.
  task automatic step(input bit f_re, input logic [31:0] f_addr, input bit d_re, input bit d_we,
                      input logic [31:0] d_addr, input logic [31:0] d_wd, input logic [3:0] d_be,
                      input bit srst);
    bit done_now;
    @(negedge clk);
    check_outputs();
    done_now = 0;
    if (inflight) begin
      if (cnt == 0) done_now = 1;
      else cnt--;
    end
    mem_done = done_now || (!inflight && stray_done);
    mem_rdata = fix_rd_en ? fix_rd : $urandom;
    fetch_re = f_re; fetch_addr = f_addr;
    data_re = d_re; data_we = d_we; data_addr = d_addr; data_wdata = d_wd; data_be = d_be;
    sync_reset = srst;

    e_fd = done_now && !srst && (in_kind == 0);
    e_dd = done_now && !srst && (in_kind == 1);
    e_dd_load = !in_we;
    e_rd = mem_rdata;
    if (e_fd && exp_q.size() > 0) e_ack = exp_q.pop_front();

    if (srst) begin
      data_busy = 0; data_unissued = 0; fetch_unissued = 0;
      exp_q.delete();
      if (inflight && !done_now) in_kind = 2;
    end else begin
      if (d_re || d_we) begin
        if (data_busy) e_ovr = 1;
        else begin
          data_busy = 1; data_unissued = 1;
          dq_we = d_we; dq_w = d_addr[17:2]; dq_wd = d_wd; dq_be = d_be;
        end
      end
      if (f_re) begin
        fetch_unissued = 1;
        fetch_w = f_addr[17:2];
      end
    end
    if (done_now) begin
      inflight = 0;
      if (in_kind == 1) data_busy = 0;
    end

    e_re = 0; e_we = 0;
    if (!srst && !inflight && (data_unissued || fetch_unissued)) begin
      inflight = 1;
      cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
      if (data_unissued) begin
        data_unissued = 0; in_kind = 1; in_we = dq_we;
        e_we = dq_we; e_re = !dq_we; e_addr = dq_w; e_wd = dq_wd; e_be = dq_be;
      end else begin
        fetch_unissued = 0; in_kind = 0; in_we = 0;
        e_re = 1; e_addr = fetch_w;
        exp_q.push_back(fetch_w);
      end
    end
    e_dram = data_busy;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, 0, 0, '0, '0, '0, 0);
  endtask

  task automatic hard_reset();
    #2 reset_n = 1'b0;
    #1;
    check("rst_mem_re", mem_re, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_fetch_done", fetch_done, 0);
    check("rst_fetch_rdata", fetch_rdata, 0);
    check("rst_fetch_ack", fetch_addr_ack, 0);
    check("rst_data_done", data_done, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_dram", dram_rw_pending, 0);
    check("rst_overrun", data_overrun, 0);
    fetch_re = 0; data_re = 0; data_we = 0; mem_done = 0; sync_reset = 0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int d0;
    stray_done = 0; fix_rd_en = 0; fix_rd = '0; mem_lat = -1;
    model_clear();
    hard_reset();

    // Single fetch from idle.
    mem_lat = 1; fix_rd_en = 1; fix_rd = 32'h13;
    step(1, 32'h100, 0, 0, '0, '0, '0, 0);
    idle(4);
    check("basic_rdata", fetch_rdata, 32'h13);
    check("basic_ack", fetch_addr_ack, 16'h40);
    fix_rd_en = 0;

    // Simultaneous fetch and store: store first, fetch right after.
    mem_lat = 2;
    step(1, 32'h200, 0, 1, 32'h8000, 32'hDEADBEEF, 4'hF, 0);
    idle(8);
    check("prio_ack", fetch_addr_ack, 16'h80);

    // Fetch redirect while the slot waits behind a load.
    mem_lat = 4; d0 = n_fd;
    step(0, '0, 1, 0, 32'h40, '0, '0, 0);
    step(1, 32'h300, 0, 0, '0, '0, '0, 0);
    step(1, 32'h400, 0, 0, '0, '0, '0, 0);
    idle(14);
    check("redirect_ack", fetch_addr_ack, 16'h100);
    check("redirect_ndone", n_fd - d0, 1);

    // Second load while the first is in flight is dropped.
    mem_lat = 4; d0 = n_dd;
    step(0, '0, 1, 0, 32'h1000, '0, '0, 0);
    step(0, '0, 1, 0, 32'h2000, '0, '0, 0);
    idle(8);
    check("overrun_flag", data_overrun, 1);
    check("overrun_ndone", n_dd - d0, 1);

    // sync_reset mid-fetch, then a fetch requested during the drain.
    mem_lat = 3; d0 = n_fd;
    step(1, 32'h500, 0, 0, '0, '0, '0, 0);
    idle(1);
    step(0, '0, 0, 0, '0, '0, '0, 1);
    step(1, 32'h600, 0, 0, '0, '0, '0, 0);
    idle(10);
    check("drain_ndone", n_fd - d0, 1);
    check("drain_ack", fetch_addr_ack, 16'h180);

    // Hard reset mid-transaction, then a stray mem_done.
    mem_lat = 5;
    step(1, 32'h700, 0, 0, '0, '0, '0, 0);
    idle(1);
    hard_reset();
    d0 = n_fd;
    stray_done = 1;
    idle(2);
    stray_done = 0;
    idle(2);
    check("stray_ndone", n_fd - d0, 0);

    // Randomized traffic with random memory latency.
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bit fr, dr, dw, sr;
      fr = ($urandom_range(0, 3) == 0);
      dr = ($urandom_range(0, 4) == 0);
      dw = ($urandom_range(0, 4) == 0);
      sr = ($urandom_range(0, 99) == 0);
      stray_done = ($urandom_range(0, 15) == 0);
      step(fr, $urandom, dr, dw, $urandom, $urandom, 4'($urandom), sr);
    end
    stray_done = 0;
    idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
